data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, is the number of 32-bit words of storage.
REQ-002 Parameter LATENCY, default 1, is the number of wait cycles in BUSY; legal range 1..4.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port load, input, 1: load request from the memory stage.
REQ-006 Port store, input, 1: store request from the memory stage.
REQ-007 Port addr, input, 32: byte address (ALU result); word index = addr[31:2]; addr[1:0] ignored.
REQ-008 Port wdata, input, 32: lane-aligned store data from byte-access logic.
REQ-009 Port mask, input, 4: byte-lane write enables; bit i enables wdata[8i+7:8i].
REQ-010 Port rdata, output, 32: full read word, returned to byte-access logic for load extraction.
REQ-011 Port stall, output, 1: freezes the pipeline while an access is in flight.
REQ-012 Port done, output, 1: one-cycle completion pulse.
REQ-013 Port err, output, 1: one-cycle error pulse, coincident with done.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-015 In IDLE or DONE, load|store high SHALL be a request: at the edge, addr word index, wdata, mask and op are latched, count <= LATENCY-1, and the FSM enters BUSY.
REQ-016 In IDLE or DONE with no request, the next state SHALL be IDLE.
REQ-017 In BUSY with count != 0, count SHALL decrement and the FSM stays in BUSY.
REQ-018 In BUSY with count == 0, the access SHALL be performed at that edge and the FSM enters DONE.
REQ-019 Latency: a request accepted at the end of cycle T SHALL put the FSM in DONE during cycle T+LATENCY+1.
REQ-020 stall SHALL be high combinationally in the request cycle and throughout BUSY, and low in DONE and in idle IDLE.
REQ-021 A store SHALL write only the bytes whose mask bit is 1; the remaining bytes keep their prior value.
REQ-022 A store with mask=4'b0000 SHALL complete normally and modify nothing.
REQ-023 A load SHALL register the addressed word into rdata at the access edge; rdata holds that value until the next load completes.
REQ-024 Stores SHALL NOT change rdata.
REQ-025 Simultaneous load and store SHALL execute as a store, and err SHALL pulse with done.
REQ-026 Word index >= DEPTH_WORDS: the write is dropped or rdata <= 0, and err SHALL pulse with done.
REQ-027 done SHALL be high exactly during the DONE cycle.
REQ-028 Back-to-back requests presented in DONE SHALL be accepted without an idle cycle.
REQ-029 Inputs changing during BUSY SHALL have no effect, because operands are latched.

Reset
REQ-030 rst_n low SHALL asynchronously force state=IDLE, count=0, rdata=0, done=0, err=0, stall=0.
REQ-031 Reset during BUSY SHALL abort the access; a pending store is not written.
REQ-032 Memory array contents SHALL NOT be cleared by reset.
REQ-033 After rst_n rises, the first request SHALL be accepted on the next rising edge.

Verification
REQ-034 LATENCY=1: store addr=0x10, wdata=0xDEADBEEF, mask=4'hF, then load 0x10 -> stall high 2 cycles; done in cycle T+2; rdata=0xDEADBEEF.
REQ-035 Byte merge: word 0x20 holds 0x11223344; store wdata=0x0000AA00, mask=4'b0010; load -> rdata=0x1122AA44.
REQ-036 load=store=1 at 0x30 with wdata=0x5, mask=4'hF -> word written to 0x00000005; err and done pulse together; rdata unchanged.
REQ-037 Load from word index DEPTH_WORDS -> rdata=0, err=1 with done; a store to the same index leaves all memory unchanged.
REQ-038 LATENCY=3: store issued, rst_n pulsed low in second BUSY cycle -> outputs zero immediately; later load of that word returns old value.
REQ-039 Back-to-back: load request held high through DONE -> second access accepted in DONE; stall low for exactly one cycle between the two accesses.

Source files
------------

// File: rtl/data_memory.sv
// Word-organised data memory with byte-lane writes and a fixed-latency
// IDLE/BUSY/DONE handshake toward the memory pipeline stage.
module data_memory #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  mask,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [1:0] LAT_M1 = 2'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_count;
    logic [29:0] r_idx;
    logic [31:0] r_wdata;
    logic [3:0]  r_mask;
    logic        r_store;
    logic        r_both;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic w_req;
    logic w_in_range;
    logic w_access;
    logic w_unused_addr;

    assign w_req         = load | store;
    assign w_in_range    = ({2'b00, r_idx} < 32'(DEPTH_WORDS));
    assign w_access      = (r_state == BUSY) && (r_count == 2'd0);
    assign w_unused_addr = &{1'b0, addr[1:0]};

    // A request seen while DONE does not stall: the pipeline must advance
    // to consume the finished result in that cycle.
    assign stall = (r_state == BUSY) || ((r_state == IDLE) && w_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= 2'd0;
            r_idx   <= 30'd0;
            r_wdata <= 32'd0;
            r_mask  <= 4'd0;
            r_store <= 1'b0;
            r_both  <= 1'b0;
            rdata   <= 32'd0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    if (w_req) begin
                        r_idx   <= addr[31:2];
                        r_wdata <= wdata;
                        r_mask  <= mask;
                        r_store <= store;
                        r_both  <= load & store;
                        r_count <= LAT_M1;
                        r_state <= BUSY;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUSY: begin
                    if (r_count != 2'd0) begin
                        r_count <= r_count - 2'd1;
                    end else begin
                        r_state <= DONE;
                        done    <= 1'b1;
                        err     <= r_both | ~w_in_range;
                        if (!r_store) begin
                            rdata <= w_in_range ? r_mem[r_idx[AW-1:0]] : 32'd0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Array has no reset; an aborted access never reaches w_access.
    always_ff @(posedge clk) begin
        if (w_access && r_store && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (r_mask[i]) begin
                    r_mem[r_idx[AW-1:0]][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: a LATENCY=1 and a LATENCY=3 instance
// share one clock; per-instance monitors check every done pulse.
module tb_data_memory;
    logic clk;
    logic rst_na, load_a, store_a, stall_a, done_a, err_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [3:0] mask_a;
    logic rst_nb, load_b, store_b, stall_b, done_b, err_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [3:0] mask_b;

    int tests = 0;
    int fails = 0;
    logic [32:0] q_a[$];
    logic [32:0] q_b[$];
    logic [32:0] ea, eb;

    data_memory #(.DEPTH_WORDS(1024), .LATENCY(1)) u_a (
        .clk(clk), .rst_n(rst_na), .load(load_a), .store(store_a),
        .addr(addr_a), .wdata(wdata_a), .mask(mask_a), .rdata(rdata_a),
        .stall(stall_a), .done(done_a), .err(err_a)
    );

    data_memory #(.DEPTH_WORDS(16), .LATENCY(3)) u_b (
        .clk(clk), .rst_n(rst_nb), .load(load_b), .store(store_b),
        .addr(addr_b), .wdata(wdata_b), .mask(mask_b), .rdata(rdata_b),
        .stall(stall_b), .done(done_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done_a === 1'b1) begin
            if (q_a.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mon_a: unexpected done");
            end else begin
                ea = q_a.pop_front();
                chk("rdata_a", rdata_a, ea[32:1]);
                chk("err_a", 32'(err_a), 32'(ea[0]));
            end
        end
        if (done_b === 1'b1) begin
            if (q_b.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mon_b: unexpected done");
            end else begin
                eb = q_b.pop_front();
                chk("rdata_b", rdata_b, eb[32:1]);
                chk("err_b", 32'(err_b), 32'(eb[0]));
            end
        end
    end

    task automatic drive(input bit b, input logic ld, input logic st,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] m);
        if (b) begin
            load_b = ld; store_b = st; addr_b = a; wdata_b = wd; mask_b = m;
        end else begin
            load_a = ld; store_a = st; addr_a = a; wdata_a = wd; mask_a = m;
        end
    endtask

    // Issue one access from IDLE, then scramble inputs while BUSY.
    task automatic acc(input bit b, input logic ld, input logic st,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] m, input logic [31:0] exp_rd,
                       input logic exp_err);
        int lat;
        int n;
        int ns;
        bit seen;
        lat = b ? 3 : 1;
        n = 0;
        ns = 0;
        seen = 0;
        if (b) q_b.push_back({exp_rd, exp_err});
        else q_a.push_back({exp_rd, exp_err});
        drive(b, ld, st, a, wd, m);
        @(negedge clk);
        if (b ? stall_b : stall_a) ns++;
        @(posedge clk);
        #1;
        drive(b, 1'b0, 1'b0, $urandom, $urandom, 4'hF);
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (b ? done_b : done_a) seen = 1;
            else if (b ? stall_b : stall_a) ns++;
        end
        chk(b ? "latency_b" : "latency_a", 32'(n), 32'(lat + 1));
        chk(b ? "stall_b" : "stall_a", 32'(ns), 32'(lat + 1));
        @(posedge clk);
        #1;
    endtask

    logic [4:0] sp, dp;

    initial begin
        rst_na = 1'b0;
        rst_nb = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (2) @(negedge clk);
        chk("rst_rdata", rdata_a, 32'd0);
        chk("rst_stall", 32'(stall_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        rst_na = 1'b1;
        rst_nb = 1'b1;
        @(posedge clk);
        #1;

        acc(0, 0, 1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 32'h0, 0);
        acc(0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 0);
        acc(0, 1, 0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 0);
        acc(0, 0, 1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'hDEAD_BEEF, 0);
        acc(0, 0, 1, 32'h0000_0020, 32'h0000_AA00, 4'b0010, 32'hDEAD_BEEF, 0);
        acc(0, 1, 0, 32'h0000_0022, 32'h0, 4'h0, 32'h1122_AA44, 0);
        acc(0, 0, 1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 32'h1122_AA44, 0);
        acc(0, 1, 0, 32'h0000_0020, 32'h0, 4'h0, 32'h1122_AA44, 0);
        acc(0, 0, 1, 32'h0000_0030, 32'h1111_1111, 4'hF, 32'h1122_AA44, 0);
        acc(0, 1, 0, 32'h0000_0030, 32'h0, 4'h0, 32'h1111_1111, 0);
        acc(0, 1, 1, 32'h0000_0030, 32'h0000_0005, 4'hF, 32'h1111_1111, 1);
        acc(0, 1, 0, 32'h0000_0030, 32'h0, 4'h0, 32'h0000_0005, 0);
        acc(0, 1, 0, 32'h0000_1000, 32'h0, 4'h0, 32'h0, 1);
        acc(0, 0, 1, 32'h0000_1000, 32'hCAFE_BABE, 4'hF, 32'h0, 1);
        acc(0, 1, 0, 32'h0000_0000, 32'h0, 4'h0, 32'h0BAD_F00D, 0);
        acc(0, 1, 0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 0);

        // Back-to-back: load held high, second address accepted in DONE.
        q_a.push_back({32'hDEAD_BEEF, 1'b0});
        q_a.push_back({32'h1122_AA44, 1'b0});
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 4'd0);
        sp = '0;
        dp = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sp[i] = stall_a;
            dp[i] = done_a;
            @(posedge clk);
            #1;
            if (i == 0) addr_a = 32'h0000_0020;
            if (i == 2) load_a = 1'b0;
        end
        chk("b2b_stall", 32'(sp), 32'(5'b01011));
        chk("b2b_done", 32'(dp), 32'(5'b10100));

        acc(1, 0, 1, 32'h0000_0008, 32'h1234_5678, 4'hF, 32'h0, 0);
        acc(1, 1, 0, 32'h0000_0008, 32'h0, 4'h0, 32'h1234_5678, 0);

        // Reset in the second BUSY cycle of a LATENCY=3 store.
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(posedge clk);
        #1;
        rst_nb = 1'b0;
        #1;
        chk("abort_stall", 32'(stall_b), 32'd0);
        chk("abort_done", 32'(done_b), 32'd0);
        chk("abort_err", 32'(err_b), 32'd0);
        chk("abort_rdata", rdata_b, 32'd0);
        @(negedge clk);
        rst_nb = 1'b1;
        @(posedge clk);
        #1;
        acc(1, 1, 0, 32'h0000_0008, 32'h0, 4'h0, 32'h1234_5678, 0);
        acc(1, 1, 0, 32'h0000_0040, 32'h0, 4'h0, 32'h0, 1);

        repeat (2) @(posedge clk);
        chk("q_a_empty", 32'(q_a.size()), 32'd0);
        chk("q_b_empty", 32'(q_b.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
